// File: rtl/op2_pkg.sv
// Shared constants for the operand-2 sequencer: shift types, internal op codes,
// FSM encoding and the register-shift count clamp.
package op2_pkg;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  // Internal op is the shift type zero-extended, plus RRX as a fifth code
  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_RRX = 3'd4;

  localparam logic [5:0] CNT_CLAMP = 6'd33;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/op2_step.sv
// Combinational single step of the iterative shifter: applies i_k bits of the
// selected op (RRX always moves exactly one bit) and reports the carry-out.
module op2_step
  import op2_pkg::*;
(
  input  logic [31:0] i_val,
  input  logic        i_carry,
  input  logic [2:0]  i_op,
  input  logic [2:0]  i_k,
  output logic [31:0] o_val,
  output logic        o_carry
);

  logic [4:0] w_k5;
  logic [4:0] w_lsl_idx;
  logic [4:0] w_rsh_idx;
  logic [5:0] w_ror_back;

  assign w_k5       = {2'b00, i_k};
  // 32-k folded into 5 bits; only evaluated for k in 1..4
  assign w_lsl_idx  = 5'd0 - w_k5;
  assign w_rsh_idx  = w_k5 - 5'd1;
  assign w_ror_back = 6'd32 - {3'b000, i_k};

  always_comb begin
    o_val   = i_val;
    o_carry = i_carry;
    if (i_op == OP_RRX) begin
      o_val   = {i_carry, i_val[31:1]};
      o_carry = i_val[0];
    end else if (i_k != 3'd0) begin
      case (i_op)
        OP_LSL: begin
          o_val   = i_val << i_k;
          o_carry = i_val[w_lsl_idx];
        end
        OP_LSR: begin
          o_val   = i_val >> i_k;
          o_carry = i_val[w_rsh_idx];
        end
        OP_ASR: begin
          o_val   = 32'($signed(i_val) >>> i_k);
          o_carry = i_val[w_rsh_idx];
        end
        OP_ROR: begin
          o_val   = (i_val >> i_k) | (i_val << w_ror_back);
          o_carry = i_val[w_rsh_idx];
        end
        default: begin
          o_val   = i_val;
          o_carry = i_carry;
        end
      endcase
    end
  end

endmodule

// File: rtl/op2_shift_ctrl.sv
// Iterative ARM operand-2 sequencer: decodes one request, runs a narrow step
// shifter for ceil(cnt/STEP) cycles, then holds the result until consumed.
module op2_shift_ctrl
  import op2_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_imm,
  input  logic [11:0] in_imm12,
  input  logic [31:0] in_rm,
  input  logic [1:0]  in_shtype,
  input  logic        in_reg_shift,
  input  logic [4:0]  in_shamt,
  input  logic [7:0]  in_rs,
  input  logic        in_cflag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op2,
  output logic        out_carry,
  output logic        busy
);

  localparam logic [2:0] STEP_K = 3'(STEP);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_val;
  logic        r_carry;
  logic [2:0]  r_op;
  logic [5:0]  r_cnt;

  logic [31:0] w_dec_val;
  logic        w_dec_carry;
  logic [2:0]  w_dec_op;
  logic [5:0]  w_dec_cnt;

  logic [2:0]  w_k;
  logic        w_last;
  logic [31:0] w_step_val;
  logic        w_step_carry;
  logic        w_accept;

  // Request decode, including the ARM special encodings for zero amounts
  always_comb begin
    w_dec_val   = in_rm;
    w_dec_carry = in_cflag;
    w_dec_op    = {1'b0, in_shtype};
    w_dec_cnt   = 6'd0;
    if (in_imm) begin
      w_dec_val = {24'b0, in_imm12[7:0]};
      w_dec_op  = OP_ROR;
      w_dec_cnt = {1'b0, in_imm12[11:8], 1'b0};
    end else if (!in_reg_shift) begin
      case (in_shtype)
        SH_LSL:  w_dec_cnt = {1'b0, in_shamt};
        SH_LSR,
        SH_ASR:  w_dec_cnt = (in_shamt == 5'd0) ? 6'd32 : {1'b0, in_shamt};
        default: begin
          if (in_shamt == 5'd0) begin
            w_dec_op  = OP_RRX;
            w_dec_cnt = 6'd1;
          end else begin
            w_dec_cnt = {1'b0, in_shamt};
          end
        end
      endcase
    end else if (in_rs != 8'd0) begin
      if (in_shtype == SH_ROR) begin
        w_dec_cnt = {1'b0, in_rs[4:0]};
        if (in_rs[4:0] == 5'd0) w_dec_carry = in_rm[31];
      end else begin
        w_dec_cnt = (in_rs > {2'b00, CNT_CLAMP}) ? CNT_CLAMP : in_rs[5:0];
      end
    end
  end

  assign w_k      = (r_cnt < {3'b000, STEP_K}) ? r_cnt[2:0] : STEP_K;
  assign w_last   = (r_cnt <= {3'b000, STEP_K});
  assign w_accept = (r_state == ST_IDLE) && in_valid;

  op2_step u_step (
    .i_val   (r_val),
    .i_carry (r_carry),
    .i_op    (r_op),
    .i_k     (w_k),
    .o_val   (w_step_val),
    .o_carry (w_step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = (w_dec_cnt == 6'd0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val   <= 32'd0;
      r_carry <= 1'b0;
      r_op    <= 3'd0;
      r_cnt   <= 6'd0;
    end else if (w_accept) begin
      r_val   <= w_dec_val;
      r_carry <= w_dec_carry;
      r_op    <= w_dec_op;
      r_cnt   <= w_dec_cnt;
    end else if (r_state == ST_SHIFT) begin
      r_val   <= w_step_val;
      r_carry <= w_step_carry;
      r_cnt   <= r_cnt - {3'b000, w_k};
    end
  end

  assign out_op2   = r_val;
  assign out_carry = r_carry;

endmodule
